// File: rtl/cnn_pkg.sv
// cnn_pkg: shared defaults, FSM state type and index helpers for the CNN store path
package cnn_pkg;
  localparam int CNN_MEM_ADDR_SIZE = 16;
  localparam int CNN_BLOCK_SIZE = 25;
  localparam int CNN_DATA_SIZE = 16;
  localparam int CNN_BUF_DEPTH = 1024;
  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;
  function automatic logic [31:0] min32(logic [31:0] a, logic [31:0] b);
    return a > b ? b : a;
  endfunction
  function automatic logic [31:0] clamp_idx(logic [31:0] idx, logic [31:0] lim);
    return idx >= lim ? lim - 32'd1 : idx;
  endfunction
endpackage

// File: rtl/block_packer.sv
// block_packer: DMA block register file capturing buffer words with padding and optional ReLU (STORE_BLOCK_RELU_EN)
module block_packer #(
  parameter int DATA_SIZE = 16,
  parameter int BLOCK_SIZE = 25,
  localparam int CW = $clog2(BLOCK_SIZE + 1)
)(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [CW-1:0]               slot,
  input  logic                        pad,
  input  logic signed [DATA_SIZE-1:0] din,
  output logic signed [DATA_SIZE-1:0] dout [BLOCK_SIZE]
);
  logic signed [DATA_SIZE-1:0] val;
  // word value after the optional negative clamp
  always_comb begin
`ifdef STORE_BLOCK_RELU_EN
    val = din[DATA_SIZE-1] ? '0 : din;
`else
    val = din;
`endif
  end
  // capture one slot per cycle; slots past the map end are zero padding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      for (int k = 0; k < BLOCK_SIZE; k++) dout[k] <= '0;
    else if (en)
      dout[slot] <= pad ? '0 : val;
  end
endmodule

// File: rtl/store_block.sv
// store_block: streams a size*size feature map from the local buffer to memory in fixed-size DMA blocks (ReLU option: STORE_BLOCK_RELU_EN)
module store_block
  import cnn_pkg::*;
#(
  parameter int MEM_ADDR_SIZE = CNN_MEM_ADDR_SIZE,
  parameter int BLOCK_SIZE = CNN_BLOCK_SIZE,
  parameter int DATA_SIZE = CNN_DATA_SIZE,
  parameter int BUF_DEPTH = CNN_BUF_DEPTH
)(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [15:0]                 size,
  input  logic [MEM_ADDR_SIZE-1:0]    address,
  output logic [9:0]                  bufAddr,
  input  logic signed [DATA_SIZE-1:0] bufData,
  output logic [MEM_ADDR_SIZE-1:0]    dmaAddr,
  output logic signed [DATA_SIZE-1:0] dmaIn [BLOCK_SIZE],
  output logic                        dmaWe,
  input  logic                        dmaAck,
  output logic                        busy,
  output logic                        done
);
  localparam int CW = $clog2(BLOCK_SIZE + 1);
  localparam logic [31:0] DEPTH = BUF_DEPTH;
  localparam logic [31:0] BLK = BLOCK_SIZE;
  localparam logic [CW-1:0] LAST = CW'(BLOCK_SIZE);
  state_t state;
  logic [MEM_ADDR_SIZE-1:0] base;
  logic [31:0] total, base_idx, total_n, widx;
  logic [CW-1:0] cnt;
  // clamp the requested word count to what the buffer can hold
  always_comb begin
    total_n = min32({16'd0, size} * {16'd0, size}, DEPTH);
    widx = base_idx + 32'(cnt) - 32'd1;
  end
  // control FSM: fill a block from the buffer, hand it to DMA, repeat until the map is stored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      base <= '0;
      total <= '0;
      base_idx <= '0;
      cnt <= '0;
      bufAddr <= '0;
      dmaAddr <= '0;
      dmaWe <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          base <= address;
          total <= total_n;
          base_idx <= '0;
          cnt <= '0;
          bufAddr <= '0;
          busy <= 1'b1;
          done <= total_n == '0;
          state <= total_n == '0 ? DONE : FILL;
        end
        FILL: begin
          cnt <= cnt == LAST ? '0 : cnt + CW'(1);
          bufAddr <= 10'(clamp_idx(base_idx + 32'(cnt) + 32'd1, DEPTH));
          if (cnt == LAST) begin
            state <= WRITE;
            dmaWe <= 1'b1;
            dmaAddr <= base + MEM_ADDR_SIZE'(base_idx);
          end
        end
        WRITE: if (dmaAck) begin
          dmaWe <= 1'b0;
          if (base_idx + BLK < total) begin
            state <= FILL;
            base_idx <= base_idx + BLK;
            bufAddr <= 10'(clamp_idx(base_idx + BLK, DEPTH));
          end else begin
            state <= DONE;
            done <= 1'b1;
          end
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  block_packer #(.DATA_SIZE(DATA_SIZE), .BLOCK_SIZE(BLOCK_SIZE)) u_packer (
    .clk(clk),
    .rst_n(rst_n),
    .en(state == FILL && cnt != '0),
    .slot(cnt - CW'(1)),
    .pad(widx >= total),
    .din(bufData),
    .dout(dmaIn)
  );
endmodule

// File: tb/tb_store_block.sv
// tb_store_block: table-driven and randomized checks of store_block against a block-level reference model
module tb_store_block;
  logic clk, rst_n, start, dmaWe, dmaAck, busy, done;
  logic [15:0] size, address, dmaAddr;
  logic [9:0] bufAddr;
  logic signed [15:0] bufData;
  logic signed [15:0] dmaIn [25];
  logic signed [15:0] mem [1024];
  logic signed [15:0] snap_data [25];
  logic [15:0] snap_addr;
  logic [15:0] q_addr [$];
  logic signed [15:0] q_words [$];
  int vectors = 0, errors = 0, cyc = 0, ack_delay = 0, wcnt = 0;
  bit noise = 0;

  typedef struct packed {
    logic [15:0] size;
    logic [15:0] base;
    logic [7:0] delay;
    logic noise;
    logic mid;
    logic [7:0] blocks;
  } vec_t;
  vec_t tbl [9];

  store_block dut (
    .clk(clk), .rst_n(rst_n), .start(start), .size(size), .address(address),
    .bufAddr(bufAddr), .bufData(bufData), .dmaAddr(dmaAddr), .dmaIn(dmaIn),
    .dmaWe(dmaWe), .dmaAck(dmaAck), .busy(busy), .done(done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc++;
  always @(posedge clk) bufData <= mem[bufAddr];

  task automatic chk(string name, longint act, longint exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic signed [15:0] relu(logic signed [15:0] v);
`ifdef STORE_BLOCK_RELU_EN
    return v < 0 ? 16'sd0 : v;
`else
    return v;
`endif
  endfunction

  // memory-side responder: acks after ack_delay cycles, records accepted blocks, checks hold stability
  always @(negedge clk) begin
    if (dmaWe) begin
      if (wcnt == 0) begin
        snap_addr = dmaAddr;
        for (int i = 0; i < 25; i++) snap_data[i] = dmaIn[i];
      end else begin
        chk("hold_addr", dmaAddr, snap_addr);
        for (int i = 0; i < 25; i++)
          if (dmaIn[i] !== snap_data[i]) chk("hold_data", dmaIn[i], snap_data[i]);
      end
      dmaAck = wcnt >= ack_delay;
      if (dmaAck) begin
        q_addr.push_back(dmaAddr);
        for (int i = 0; i < 25; i++) q_words.push_back(dmaIn[i]);
      end
      wcnt++;
    end else begin
      dmaAck = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      wcnt = 0;
    end
  end

  task automatic run_op(input logic [15:0] sz, input logic [15:0] bs, input int dly,
                        input bit nz, input bit mid, input int exp_blocks);
    longint total, nblk, lat_exp, w;
    int lat, busy_n;
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    mem[0] = -16'sd300;
    mem[1] = 16'sd300;
    q_addr.delete();
    q_words.delete();
    ack_delay = dly;
    noise = nz;
    @(negedge clk);
    start = 1;
    size = sz;
    address = bs;
    lat = cyc;
    @(negedge clk);
    start = 0;
    size = 16'($urandom);
    address = 16'($urandom);
    busy_n = 0;
    for (int k = 1; k <= 60000; k++) begin
      if (busy) busy_n++;
      if (done) begin
        lat = cyc - lat;
        break;
      end
      if (k == 60000) begin
        lat = -1;
        break;
      end
      start = mid && k == 10;
      @(negedge clk);
    end
    start = 0;
    total = longint'(sz) * longint'(sz);
    if (total > 1024) total = 1024;
    nblk = (total + 24) / 25;
    lat_exp = nblk * (27 + dly) + 1;
    chk("latency", lat, lat_exp);
    chk("busy_cycles", busy_n, lat_exp);
    if (exp_blocks >= 0) chk("block_count_table", nblk, exp_blocks);
    chk("writes", q_addr.size(), nblk);
    for (int b = 0; b < nblk && b < q_addr.size(); b++) begin
      chk("dma_addr", q_addr[b], (bs + 25 * b) & 16'hFFFF);
      for (int i = 0; i < 25; i++) begin
        w = 25 * b + i;
        chk("dma_data", q_words[25 * b + i], w < total ? relu(mem[w]) : 16'sd0);
      end
    end
    @(negedge clk);
    chk("done_single", done, 0);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    bit any;
    int seen;
    tbl[0] = '{16'd5, 16'h0100, 8'd0, 1'b0, 1'b0, 8'd1};
    tbl[1] = '{16'd7, 16'h0200, 8'd0, 1'b0, 1'b0, 8'd2};
    tbl[2] = '{16'd0, 16'h0300, 8'd0, 1'b0, 1'b0, 8'd0};
    tbl[3] = '{16'd5, 16'h0400, 8'd3, 1'b0, 1'b1, 8'd1};
    tbl[4] = '{16'd33, 16'h1000, 8'd0, 1'b0, 1'b0, 8'd41};
    tbl[5] = '{16'd10, 16'hFFF0, 8'd1, 1'b1, 1'b0, 8'd4};
    tbl[6] = '{16'd1, 16'h0005, 8'd2, 1'b1, 1'b1, 8'd1};
    tbl[7] = '{16'd256, 16'h0000, 8'd0, 1'b0, 1'b0, 8'd41};
    tbl[8] = '{16'hFFFF, 16'h2000, 8'd0, 1'b1, 1'b0, 8'd41};
    start = 0;
    size = 0;
    address = 0;
    rst_n = 1;
    #3 rst_n = 0;
    #1;
    any = 0;
    for (int i = 0; i < 25; i++) any |= dmaIn[i] != 0;
    chk("reset_outputs", {dmaWe, busy, done, dmaAddr != 0, bufAddr != 0, any}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int t = 0; t < 9; t++) begin
      run_op(tbl[t].size, tbl[t].base, int'(tbl[t].delay), tbl[t].noise, tbl[t].mid, int'(tbl[t].blocks));
      if (t == 0) begin
        chk("relu_neg", q_words.size() > 0 ? q_words[0] : 16'sh7fff,
`ifdef STORE_BLOCK_RELU_EN
            0
`else
            -300
`endif
        );
        chk("relu_pos", q_words.size() > 1 ? q_words[1] : 16'sh7fff, 300);
      end
      if (t == 1) chk("second_addr", q_addr.size() > 1 ? q_addr[1] : 16'h0, 16'h0219);
    end
    for (int r = 0; r < 8; r++)
      run_op(16'($urandom_range(0, 40)), 16'($urandom), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    ack_delay = 1000000;
    noise = 0;
    @(negedge clk);
    start = 1;
    size = 7;
    address = 16'h0500;
    @(negedge clk);
    start = 0;
    seen = 0;
    for (int k = 0; k < 100 && !dmaWe; k++) @(negedge clk);
    chk("write_reached", dmaWe, 1);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    any = 0;
    for (int i = 0; i < 25; i++) any |= dmaIn[i] != 0;
    chk("midwrite_reset", {dmaWe, busy, done, dmaAddr != 0, bufAddr != 0, any}, 0);
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dmaWe || busy) seen++;
    end
    chk("idle_after_reset", seen, 0);
    ack_delay = 0;
    run_op(16'd5, 16'h0100, 0, 1'b0, 1'b0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/store_block.md
STORE_BLOCK -- requirements
Module: store_block

Interface
REQ-001 SHALL have parameters: MEM_ADDR_SIZE, default 16, memory address width; BLOCK_SIZE, default 25, words per DMA block; DATA_SIZE, default 16, signed word width; BUF_DEPTH, default 1024, local buffer words.
REQ-002 SHALL have ports: clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have ports: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: start  input  1  one-cycle request to store a feature map.
REQ-005 SHALL have ports: size  input  16  map side length, word count = size*size.
REQ-006 SHALL have ports: address  input  MEM_ADDR_SIZE  memory base address of the map.
REQ-007 SHALL have ports: bufAddr  output  10  local buffer read address.
REQ-008 SHALL have ports: bufData  input  DATA_SIZE signed  buffer read data, valid one cycle after bufAddr.
REQ-009 SHALL have ports: dmaAddr  output  MEM_ADDR_SIZE  block write address.
REQ-010 SHALL have ports: dmaIn  output  DATA_SIZE x BLOCK_SIZE signed unpacked array  block write data.
REQ-011 SHALL have ports: dmaWe  output  1  block write request; dmaAck  input  1  memory accepted the block.
REQ-012 SHALL have ports: busy  output  1  operation in progress; done  output  1  one-cycle completion pulse.

Function
REQ-013 SHALL implement FSM states IDLE, FILL, WRITE, DONE.
REQ-014 In IDLE, start=1 SHALL latch size and address, set total = min(size*size, BUF_DEPTH) (32-bit product, no truncation), block index = 0, and go to FILL, or to DONE if total = 0.
REQ-015 start SHALL be ignored outside IDLE.
REQ-016 FILL SHALL last BLOCK_SIZE+1 cycles: cycles 0..24 drive bufAddr = blk*25+i, cycles 1..25 capture bufData into dmaIn[i-1].
REQ-017 Slots whose word index is >= total SHALL be captured as 0 (last-block padding); bufAddr beyond total is don't-care but SHALL stay < BUF_DEPTH.
REQ-018 WRITE SHALL assert dmaWe with dmaAddr = base + 25*blk (modulo 2^MEM_ADDR_SIZE) and hold dmaAddr, dmaIn and dmaWe stable until dmaAck is sampled high.
REQ-019 On dmaAck in WRITE, dmaWe SHALL drop the next cycle; go to FILL with blk+1 if (blk+1)*25 < total, else go to DONE.
REQ-020 dmaAck outside WRITE SHALL be ignored.
REQ-021 DONE SHALL assert done for exactly one cycle, then return to IDLE; busy = 1 in FILL, WRITE and DONE.
REQ-022 Block count SHALL be ceil(total/25); minimum latency per block = 27 cycles (26 FILL + 1 WRITE with immediate ack).

Reset
REQ-023 rst_n low SHALL asynchronously force IDLE and zero bufAddr, dmaAddr, all dmaIn, dmaWe, busy, done, counters.
REQ-024 Reset during WRITE SHALL drop dmaWe immediately; no partial-block retry after reset.

Configuration
REQ-025 With STORE_BLOCK_RELU_EN defined, each captured word SHALL be replaced by 0 if negative (ReLU on store); padding unaffected.
REQ-026 Without STORE_BLOCK_RELU_EN, words SHALL be stored unmodified.

Structure
REQ-027 MEM_ADDR_SIZE, DATA_SIZE, BLOCK_SIZE, BUF_DEPTH defaults and the FSM state enum SHALL live in the shared package cnn_pkg.
REQ-028 The block-word capture/pad/ReLU register file SHALL be one sub-module, block_packer; all else in store_block.

Verification
REQ-029 size=5, base=0x0100, ack immediate -> one block, dmaAddr=0x0100, dmaIn = buf[0..24], done 28 cycles after start.
REQ-030 size=7, base=0x0200 -> two writes at 0x0200 and 0x0219; second block dmaIn[0..23]=buf[25..48], dmaIn[24]=0.
REQ-031 size=0 -> no dmaWe, done pulses the cycle after DONE entry, busy high one cycle.
REQ-032 dmaAck delayed 3 cycles -> dmaWe, dmaAddr, dmaIn stable for 4 cycles; start pulsed meanwhile ignored.
REQ-033 size=33 -> total clamped to 1024, 41 writes, last block dmaIn[24]=0; rst_n low mid-WRITE -> all outputs 0 same cycle, FSM IDLE.
REQ-034 With STORE_BLOCK_RELU_EN, buf word -300 -> stored 0, +300 -> stored 300; without macro -300 stored as -300.
